// File: rtl/hasti_apb_bridge.sv
// ---------------------------------------------------------------------------
// hasti_apb_bridge
//   HASTI (AHB-Lite) slave to APB3 master bridge. Each accepted HASTI transfer
//   becomes one APB SETUP/ACCESS pair. APB wait states stretch the HASTI data
//   phase, and pslverr is returned as a two-cycle ERROR response. Only one
//   transfer is in flight at a time.
//
// Ports
//   hclk, hreset            clock, synchronous active-high reset
//   hsel, haddr, hwrite,    HASTI address phase (qualified by hready_in)
//   hsize, htrans
//   hwdata                  HASTI write data (data phase)
//   hreadyout, hresp,       HASTI slave response; hrdata holds the last read
//   hrdata
//   paddr, psel, penable,   APB3 master request
//   pwrite, pwdata, pstrb
//   pready, prdata, pslverr APB3 completer response
// ---------------------------------------------------------------------------
module hasti_apb_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [1:0]    htrans,
    input  logic [DW-1:0] hwdata,
    input  logic          hready_in,
    output logic          hreadyout,
    output logic          hresp,
    output logic [DW-1:0] hrdata,
    output logic [AW-1:0] paddr,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [DW-1:0] pwdata,
    output logic [3:0]    pstrb,
    input  logic          pready,
    input  logic [DW-1:0] prdata,
    input  logic          pslverr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDAT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state;
    state_t state_next;

    logic       accept;
    logic       legal;
    logic [3:0] strb_next;

    // htrans[0] only separates BUSY from IDLE and NONSEQ from SEQ; both
    // pairs are handled identically here.
    logic unused_htrans0;
    assign unused_htrans0 = htrans[0];

    // hreadyout is only high in IDLE and ERR2, so this is exactly
    // "a new address phase arrives while we can take it".
    assign accept = hsel & htrans[1] & hready_in & hreadyout;

    // Size/alignment legality and byte strobes for the incoming address phase.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        legal     = 1'b0;
        strb_next = 4'b0000;
        case (hsize)
            3'd0: begin
                legal     = 1'b1;
                strb_next = 4'b0001 << haddr[1:0];
            end
            3'd1: begin
                legal     = ~haddr[0];
                strb_next = 4'b0011 << haddr[1:0];
            end
            3'd2: begin
                legal     = (haddr[1:0] == 2'b00);
                strb_next = 4'b1111;
            end
            default: begin
                legal     = 1'b0;
                strb_next = 4'b0000;
            end
        endcase
        if (!hwrite) begin
            strb_next = 4'b0000;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (accept) begin
                    if (!legal) begin
                        state_next = S_ERR1;
                    end else if (hwrite) begin
                        state_next = S_WDAT;   // wait one cycle for hwdata
                    end else begin
                        state_next = S_SETUP;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WDAT:   state_next = S_SETUP;
            S_SETUP:  state_next = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    state_next = pslverr ? S_ERR1 : S_IDLE;
                end
            end
            S_ERR1:   state_next = S_ERR2;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from state_next and registered, so they change
    // together with the state they belong to and never glitch.
    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (hreset) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= 4'b0000;
        end else begin
            state     <= state_next;
            hreadyout <= (state_next == S_IDLE) || (state_next == S_ERR2);
            hresp     <= (state_next == S_ERR1) || (state_next == S_ERR2);
            psel      <= (state_next == S_SETUP) || (state_next == S_ACCESS);
            penable   <= (state_next == S_ACCESS);

            // Request fields are captured once at accept and held through
            // SETUP and ACCESS.
            if (accept) begin
                paddr  <= haddr;
                pwrite <= hwrite;
                pstrb  <= strb_next;
            end

            if (state == S_WDAT) begin
                pwdata <= hwdata;
            end

            if ((state == S_ACCESS) && pready && !pslverr && !pwrite) begin
                hrdata <= prdata;
            end
        end
    end

endmodule

// File: tb/tb_hasti_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_hasti_apb_bridge
//   Self-checking bench for hasti_apb_bridge. Each transfer pushes its
//   expected response (data-phase length, hresp, hrdata, APB phase counts)
//   to a scoreboard queue when the address phase is driven; the entry is
//   popped and compared when the DUT raises hreadyout. A small APB completer
//   answers inside the transfer task with a programmable wait count/error.
// ---------------------------------------------------------------------------
module tb_hasti_apb_bridge;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    always #5 hclk = ~hclk;

    // Single slave on the bus: the bus hready is this slave's hreadyout.
    assign hready_in = hreadyout;

    hasti_apb_bridge #(.AW(32), .DW(32)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hready_in (hready_in),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    typedef struct {
        int          cycles;
        logic        resp;
        logic [31:0] rdata;
        int          setups;
        int          accesses;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_hrdata = 32'h0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Runs one HASTI transfer. Called at posedge+1 in a cycle where
    // hreadyout=1; returns at posedge+1 of the final data-phase cycle, so the
    // next call overlaps its address phase with that cycle.
    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic wr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            input logic [31:0] sdata, input int waits, input logic err);
        exp_t       e;
        exp_t       got;
        logic       legal;
        logic [3:0] strb;
        int         cycles;
        int         setups;
        int         accesses;
        int         apb_bad;
        logic       prev_resp;

        legal = (size == 3'd0) || (size == 3'd1 && !addr[0]) ||
                (size == 3'd2 && addr[1:0] == 2'b00);
        if (!wr)              strb = 4'b0000;
        else if (size == 3'd0) strb = 4'b0001 << addr[1:0];
        else if (size == 3'd1) strb = 4'b0011 << addr[1:0];
        else                   strb = 4'b1111;
        if (legal && !wr && !err) model_hrdata = sdata;

        e.cycles   = !legal ? 2 : ((wr ? 4 : 3) + waits + (err ? 1 : 0));
        e.resp     = !legal || err;
        e.rdata    = model_hrdata;
        e.setups   = legal ? 1 : 0;
        e.accesses = legal ? waits + 1 : 0;
        sb.push_back(e);

        hsel = 1'b1; htrans = 2'd2; haddr = addr; hwrite = wr; hsize = size;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = wdata;

        cycles = 1; setups = 0; accesses = 0; apb_bad = 0; prev_resp = 1'b0;
        while (!hreadyout && cycles < 40) begin
            pready = 1'b0; pslverr = 1'b0;
            if (psel) begin
                if (paddr !== addr || pwrite !== wr || pstrb !== strb ||
                    (wr && pwdata !== wdata)) apb_bad++;
                if (penable) begin
                    pready  = (accesses == waits);
                    pslverr = err && (accesses == waits);
                    prdata  = sdata;
                    accesses++;
                end else begin
                    setups++;
                end
            end
            prev_resp = hresp;
            @(posedge hclk); #1;
            cycles++;
        end
        pready = 1'b0; pslverr = 1'b0;

        got = sb.pop_front();
        if (!hreadyout) check({tag, "_timeout"}, 1, 0);
        check({tag, "_cycles"},   cycles,   got.cycles);
        check({tag, "_hresp"},    hresp,    got.resp);
        check({tag, "_hrdata"},   hrdata,   got.rdata);
        check({tag, "_setups"},   setups,   got.setups);
        check({tag, "_accesses"}, accesses, got.accesses);
        check({tag, "_apb_hold"}, apb_bad,  0);
        check({tag, "_psel_off"}, psel,     1'b0);
        if (got.resp) check({tag, "_err1_hresp"}, prev_resp, 1'b1);
    endtask

    initial begin
        hreset = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd0;
        htrans = 2'd0; hwdata = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        check("rst_hreadyout", hreadyout, 1'b1);
        check("rst_hresp",     hresp,     1'b0);
        check("rst_hrdata",    hrdata,    32'h0);
        check("rst_psel_pen",  {psel, penable, pwrite}, 3'b000);
        check("rst_paddr",     paddr,     32'h0);
        check("rst_pwdata",    pwdata,    32'h0);
        check("rst_pstrb",     pstrb,     4'h0);
        hreset = 1'b0;

        run_xfer("rd_word",    32'h40,  1'b0, 3'd2, 32'h0,        32'hCAFE_F00D, 0, 1'b0);
        run_xfer("wr_byte",    32'h43,  1'b1, 3'd0, 32'h1122_3344, 32'h0,        0, 1'b0);
        run_xfer("rd_wait5",   32'h100, 1'b0, 3'd2, 32'h0,        32'h1234_5678, 5, 1'b0);
        run_xfer("wr_slverr",  32'h44,  1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0,        0, 1'b1);
        run_xfer("rd_in_err2", 32'h52,  1'b0, 3'd1, 32'h0,        32'hA5A5_5A5A, 0, 1'b0);
        run_xfer("ill_word42", 32'h42,  1'b0, 3'd2, 32'h0,        32'h0,         0, 1'b0);
        run_xfer("ill_size3",  32'h40,  1'b0, 3'd3, 32'h0,        32'h0,         0, 1'b0);
        run_xfer("wr_half",    32'h46,  1'b1, 3'd1, 32'hBEEF_0001, 32'h0,        2, 1'b0);
        run_xfer("rd_slverr",  32'h60,  1'b0, 3'd2, 32'h0,        32'h7777_7777, 1, 1'b1);
        run_xfer("ill_half41", 32'h41,  1'b1, 3'd1, 32'h5555_5555, 32'h0,        0, 1'b0);

        // hsel with BUSY then IDLE: zero-wait OKAY, no APB activity.
        hsel = 1'b1; htrans = 2'd1; haddr = 32'h80; hwrite = 1'b0; hsize = 3'd2;
        @(posedge hclk); #1;
        check("busy_ready", {hreadyout, hresp, psel}, 3'b100);
        htrans = 2'd0;
        @(posedge hclk); #1;
        check("idle_ready", {hreadyout, hresp, psel}, 3'b100);
        hsel = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            sz = 3'($urandom_range(0, 2));
            a  = $urandom & 32'h0000_0FFC;
            if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
            if (sz == 3'd1) a[1]   = 1'($urandom_range(0, 1));
            run_xfer($sformatf("rnd%0d", i), a, 1'($urandom_range(0, 1)), sz, $urandom,
                     $urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        // Make sure hrdata is nonzero before the reset abort test.
        run_xfer("rd_prerst", 32'h70, 1'b0, 3'd2, 32'h0, 32'h0BAD_CAFE, 0, 1'b0);

        // Reset during ACCESS aborts the APB transfer on the next cycle.
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h80; hwrite = 1'b0; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'd0; pready = 1'b0;
        @(posedge hclk); #1;
        check("rstacc_access", {psel, penable}, 2'b11);
        hreset = 1'b1;
        @(posedge hclk); #1;
        check("rstacc_psel",      {psel, penable}, 2'b00);
        check("rstacc_hreadyout", hreadyout, 1'b1);
        check("rstacc_hrdata",    hrdata,    32'h0);
        hreset = 1'b0;
        model_hrdata = 32'h0;

        run_xfer("rd_postrst", 32'h84, 1'b0, 3'd2, 32'h0, 32'h600D_D00D, 0, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
